// File: rtl/muldiv_if.sv
// Request/response bundle for muldiv_unit.
// master drives requests and result acceptance; slave is the arithmetic unit.
interface muldiv_if #(
   parameter int unsigned WIDTH = 32
);
   logic             in_valid;
   logic             in_ready;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] result;
   logic             busy;

   modport master (
      output in_valid, op, a, b, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, op, a, b, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Optional macro MULDIV_EARLY_OUT_EN: divide-by-zero and signed-overflow requests skip
// the iteration phase and complete one cycle after accept.
module muldiv_unit #(
   parameter int unsigned WIDTH = 32
) (
   input logic     clk,
   input logic     reset_n,
   muldiv_if.slave bus
);
   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

   state_e             state_q, state_d;
   logic [2:0]         op_q;
   logic               sa_q, sb_q, div0_q;
   logic [WIDTH-1:0]   opb_q;            // multiplicand (mul) or divisor (div) magnitude
   logic [2*WIDTH-1:0] acc_q, acc_d;     // {hi, lo}: {product high, multiplier} / {rem, quo}
   logic [CntW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0]   result_q, result_d;

   logic             is_div, sign_a, sign_b, sa, sb, div0, early, accept;
   logic [WIDTH-1:0] mag_a, mag_b, early_res;
`ifdef MULDIV_EARLY_OUT_EN
   logic             ovf;
`endif

   // Decode the incoming request: signedness, magnitudes and special cases
   always_comb begin
      is_div    = bus.op[2];
      sign_a    = (bus.op == 3'd1) || (bus.op == 3'd2) || (bus.op == 3'd4) || (bus.op == 3'd6);
      sign_b    = (bus.op == 3'd1) || (bus.op == 3'd4) || (bus.op == 3'd6);
      sa        = sign_a & bus.a[WIDTH-1];
      sb        = sign_b & bus.b[WIDTH-1];
      mag_a     = sa ? -bus.a : bus.a;
      mag_b     = sb ? -bus.b : bus.b;
      div0      = is_div && (bus.b == '0);
      // op[1] selects remainder among the divide ops
      early_res = div0 ? (bus.op[1] ? bus.a : '1) : (bus.op[1] ? '0 : bus.a);
`ifdef MULDIV_EARLY_OUT_EN
      ovf       = is_div && !bus.op[0] && (bus.a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                  (bus.b == '1);
      early     = div0 | ovf;
`else
      early     = 1'b0;
`endif
   end

   logic [WIDTH-1:0]   hi, lo, quo, rem, fin;
   logic [WIDTH:0]     sum, shifted, diff;
   logic [2*WIDTH-1:0] iter, prod;

   // One shift-add or restoring-divide step, plus sign-corrected final result
   always_comb begin
      hi      = acc_q[2*WIDTH-1:WIDTH];
      lo      = acc_q[WIDTH-1:0];
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, opb_q} : '0);
      shifted = {hi, lo[WIDTH-1]};
      diff    = shifted - {1'b0, opb_q};
      if (op_q[2]) begin
         // Negative difference means the divisor does not fit: keep the shifted remainder
         iter = diff[WIDTH] ? {shifted[WIDTH-1:0], lo[WIDTH-2:0], 1'b0}
                            : {diff[WIDTH-1:0], lo[WIDTH-2:0], 1'b1};
      end else begin
         iter = {sum, lo[WIDTH-1:1]};
      end
      prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
      quo  = div0_q ? '1 : ((sa_q ^ sb_q) ? -lo : lo);
      rem  = sa_q ? -hi : hi;
      if (op_q[2]) begin
         fin = op_q[1] ? rem : quo;
      end else begin
         fin = (op_q[1:0] == 2'd0) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
      end
   end

   // Next-state and datapath update for IDLE -> CALC -> DONE -> IDLE
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      accept   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (bus.in_valid) begin
               accept = 1'b1;
               cnt_d  = '0;
               if (early) begin
                  state_d  = StDone;
                  result_d = early_res;
               end else begin
                  state_d = StCalc;
                  acc_d   = {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
               end
            end
         end
         StCalc: begin
            // WIDTH iterations, then one cycle to apply sign correction
            if (cnt_q == CntW'(WIDTH)) begin
               state_d  = StDone;
               result_d = fin;
            end else begin
               acc_d = iter;
               cnt_d = cnt_q + 1'b1;
            end
         end
         StDone: begin
            if (bus.out_ready) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   // State, counter, accumulator and result registers
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= StIdle;
         acc_q    <= '0;
         cnt_q    <= '0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         result_q <= result_d;
      end
   end

   // Capture operation and operand info on accept; later input changes are ignored
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         op_q   <= '0;
         sa_q   <= 1'b0;
         sb_q   <= 1'b0;
         div0_q <= 1'b0;
         opb_q  <= '0;
      end else if (accept) begin
         op_q   <= bus.op;
         sa_q   <= sa;
         sb_q   <= sb;
         div0_q <= div0;
         opb_q  <= is_div ? mag_b : mag_a;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.busy      = (state_q != StIdle);
   assign bus.out_valid = (state_q == StDone);
   assign bus.result    = result_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH=32): arithmetic reference model with
// scoreboard plus directed vectors with literal expected results.
module tb_muldiv_unit;
   localparam int unsigned W = 32;

   logic clk = 1'b0;
   logic reset_n;

   muldiv_if #(.WIDTH(W)) bus ();

   muldiv_unit #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Reference results straight from the arithmetic definitions
   function automatic logic [W-1:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
      longint     sp;
      logic [63:0] up;
      case (op)
         3'd0: begin up = {32'b0, a} * {32'b0, b}; return up[31:0]; end
         3'd1: begin sp = longint'($signed(a)) * longint'($signed(b)); return sp[63:32]; end
         3'd2: begin sp = longint'($signed(a)) * longint'({32'b0, b}); return sp[63:32]; end
         3'd3: begin up = {32'b0, a} * {32'b0, b}; return up[63:32]; end
         3'd4: begin
            if (b == 0) return 32'hffff_ffff;
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) return a;
            return 32'($signed(a) / $signed(b));
         end
         3'd5: return (b == 0) ? 32'hffff_ffff : a / b;
         3'd6: begin
            if (b == 0) return a;
            if (a == 32'h8000_0000 && b == 32'hffff_ffff) return 32'h0;
            return 32'($signed(a) % $signed(b));
         end
         default: return (b == 0) ? a : a % b;
      endcase
   endfunction

   function automatic int exp_lat(input logic [2:0] op, input logic [W-1:0] a,
                                  input logic [W-1:0] b);
`ifdef MULDIV_EARLY_OUT_EN
      if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hffff_ffff)))
         return 1;
`endif
      return W + 1;
   endfunction

   // Scoreboard: every accepted request must produce its model result after its latency
   logic [W-1:0] exp_q[$];
   int           lat_q[$];
   int           acc_cyc_q[$];
   bit           seen;

   always @(negedge clk) begin
      if (!reset_n) begin
         exp_q.delete();
         lat_q.delete();
         acc_cyc_q.delete();
         seen = 1'b0;
         chk("rst_out_valid", W'(bus.out_valid), '0);
         chk("rst_in_ready", W'(bus.in_ready), 1);
         chk("rst_busy", W'(bus.busy), '0);
         chk("rst_result", bus.result, '0);
      end else begin
         chk("busy_vs_ready", W'(bus.busy), W'(!bus.in_ready));
         if (bus.out_valid) begin
            if (exp_q.size() == 0) begin
               n_tests++;
               n_fail++;
               $display("FAIL spurious_out_valid: got result %h, expected no output",
                        bus.result);
            end else begin
               chk("sb_result", bus.result, exp_q[0]);
               chk("sb_in_ready_done", W'(bus.in_ready), '0);
               if (!seen) begin
                  chk("sb_latency", W'(cyc - acc_cyc_q[0]), W'(lat_q[0]));
                  seen = 1'b1;
               end
               if (bus.out_ready) begin
                  void'(exp_q.pop_front());
                  void'(lat_q.pop_front());
                  void'(acc_cyc_q.pop_front());
                  seen = 1'b0;
               end
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(model(bus.op, bus.a, bus.b));
            lat_q.push_back(exp_lat(bus.op, bus.a, bus.b));
            acc_cyc_q.push_back(cyc + 1);
         end
      end
   end

   // Present a request and return #1 after the accept edge
   task automatic start_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      bit ok = 1'b0;
      bus.in_valid = 1'b1;
      bus.op       = op;
      bus.a        = a;
      bus.b        = b;
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) begin
         n_tests++;
         n_fail++;
         $display("FAIL accept_timeout: in_ready %b, expected 1", bus.in_ready);
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   // Wait for the result, check it, optionally stall out_ready and scramble inputs
   task automatic finish_op(input string name, input logic [W-1:0] exp, input int hold,
                            input bit scramble);
      bit got = 1'b0;
      bus.out_ready = (hold == 0);
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (bus.out_valid) begin
            got = 1'b1;
            break;
         end
         @(posedge clk);
         #1;
         if (scramble) begin
            bus.op = 3'($urandom);
            bus.a  = $urandom;
            bus.b  = $urandom;
         end
      end
      if (!got) begin
         n_tests++;
         n_fail++;
         $display("FAIL %s_timeout: out_valid %b, expected 1", name, bus.out_valid);
      end else begin
         chk(name, bus.result, exp);
         for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            bus.in_valid = (h == 2);
            if (h == 2) begin
               bus.op = 3'd0;
               bus.a  = 32'd5;
               bus.b  = 32'd6;
            end
            @(negedge clk);
            chk({name, "_hold_valid"}, W'(bus.out_valid), 1);
            chk({name, "_hold_in_ready"}, W'(bus.in_ready), '0);
            chk({name, "_hold_result"}, bus.result, exp);
         end
      end
      @(posedge clk);
      #1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      if (hold > 0) begin
         @(posedge clk);
         #1;
      end
      chk({name, "_back_idle"}, W'(bus.in_ready), 1);
   endtask

   task automatic run(input string name, input logic [2:0] op, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [W-1:0] exp);
      start_op(op, a, b);
      finish_op(name, exp, 0, 1'b0);
   endtask

   initial begin
      reset_n       = 1'b0;
      bus.in_valid  = 1'b0;
      bus.op        = 3'd0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      #1;
      chk("init_out_valid", W'(bus.out_valid), '0);
      chk("init_in_ready", W'(bus.in_ready), 1);
      chk("init_result", bus.result, '0);
      repeat (2) @(posedge clk);
      #1;
      reset_n = 1'b1;

      run("mulhsu_m1x2", 3'd2, 32'hffff_ffff, 32'h0000_0002, 32'hffff_ffff);
      run("mul_m1x2", 3'd0, 32'hffff_ffff, 32'h0000_0002, 32'hffff_fffe);
      run("mul_shift", 3'd0, 32'h1234_5678, 32'h0000_0010, 32'h2345_6780);
      run("mulh_neg", 3'd1, 32'hffff_fffd, 32'h0000_0005, 32'hffff_ffff);
      run("mulh_minmin", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
      run("mulh_zero", 3'd1, 32'h0000_0000, 32'hffff_ffff, 32'h0000_0000);
      run("mulhsu_zero", 3'd2, 32'hffff_ffff, 32'h0000_0000, 32'h0000_0000);
      run("div_m7_2", 3'd4, 32'hffff_fff9, 32'h0000_0002, 32'hffff_fffd);
      run("rem_m7_2", 3'd6, 32'hffff_fff9, 32'h0000_0002, 32'hffff_ffff);
      run("divu_7_2", 3'd5, 32'h0000_0007, 32'h0000_0002, 32'h0000_0003);
      run("divu_max_1", 3'd5, 32'hffff_ffff, 32'h0000_0001, 32'hffff_ffff);
      run("div_ovf", 3'd4, 32'h8000_0000, 32'hffff_ffff, 32'h8000_0000);
      run("rem_ovf", 3'd6, 32'h8000_0000, 32'hffff_ffff, 32'h0000_0000);
      run("divu_by0", 3'd5, 32'h0000_1234, 32'h0000_0000, 32'hffff_ffff);
      run("remu_by0", 3'd7, 32'h0000_1234, 32'h0000_0000, 32'h0000_1234);
      run("div_m7_by0", 3'd4, 32'hffff_fff9, 32'h0000_0000, 32'hffff_ffff);
      run("rem_m7_by0", 3'd6, 32'hffff_fff9, 32'h0000_0000, 32'hffff_fff9);

      // Result held while the consumer stalls; in_valid pulse inside the stall
      start_op(3'd7, 32'd1000, 32'd7);
      finish_op("remu_hold", 32'd6, 5, 1'b0);

      // Inputs scrambled while the operation is in flight
      start_op(3'd3, 32'h8000_0000, 32'h0000_0004);
      finish_op("mulhu_scramble", 32'h0000_0002, 0, 1'b1);
      start_op(3'd4, 32'hffff_ff9c, 32'd7);
      finish_op("div_scramble", 32'hffff_fff2, 0, 1'b1);
      start_op(3'd7, 32'd1000, 32'd7);
      finish_op("remu_scramble", 32'd6, 0, 1'b1);

      // Reset in the middle of the iteration phase abandons the operation
      start_op(3'd0, 32'h1234_5678, 32'h9abc_def0);
      repeat (10) @(posedge clk);
      #2;
      reset_n = 1'b0;
      #1;
      chk("midrst_out_valid", W'(bus.out_valid), '0);
      chk("midrst_in_ready", W'(bus.in_ready), 1);
      chk("midrst_busy", W'(bus.busy), '0);
      chk("midrst_result", bus.result, '0);
      @(posedge clk);
      #1;
      reset_n = 1'b1;
      run("mulhu_after_rst", 3'd3, 32'hffff_ffff, 32'hffff_ffff, 32'hffff_fffe);

      repeat (3) @(posedge clk);
      #1;
      chk("final_queue_empty", W'(exp_q.size()), '0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32, giving the operand and result width in bits; legal values are even integers of 8 or more.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-003 SHALL have port reset_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port in_valid  input  1  request valid.
REQ-005 SHALL have port in_ready  output  1  unit can accept a request.
REQ-006 SHALL have port op  input  3  operation select: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
REQ-007 SHALL have port a  input  WIDTH  first operand (dividend / multiplicand).
REQ-008 SHALL have port b  input  WIDTH  second operand (divisor / multiplier).
REQ-009 SHALL have port out_valid  output  1  result valid.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port result  output  WIDTH  operation result.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.

Function
REQ-013 SHALL implement the FSM IDLE -> CALC -> DONE -> IDLE.
REQ-014 SHALL drive in_ready high only in IDLE; a request is accepted on a rising edge with in_valid=1 and in_ready=1.
REQ-015 SHALL, on acceptance, register op, the operand sign flags, and the operand magnitudes, then enter CALC.
- Signed operands: a and b for MULH, DIV, REM; a only for MULHSU.
REQ-016 SHALL, in CALC, perform exactly WIDTH iterations at one per cycle.
- Multiply: shift-add into a 2*WIDTH accumulator.
- Divide: restoring, one quotient bit per iteration.
- After the last iteration, enter DONE.
REQ-017 SHALL apply sign correction on entry to DONE (two's complement of magnitudes):
- product sign = sa^sb;
- quotient sign = sa^sb;
- remainder sign = sa.
REQ-018 SHALL select the result as follows:
- MUL: low WIDTH bits of the product;
- MULH, MULHSU, MULHU: high WIDTH bits of the product;
- DIV, DIVU: quotient;
- REM, REMU: remainder.
REQ-019 SHALL, on divide by zero (b=0), return quotient all-ones and remainder a, for both signed and unsigned ops.
REQ-020 SHALL, on signed overflow (DIV or REM with a = most-negative and b = -1), return quotient a and remainder 0.
REQ-021 SHALL assert out_valid exactly WIDTH+1 cycles after the accept edge; the macro exception is REQ-029.
REQ-022 SHALL hold out_valid and result stable in DONE until out_ready=1 is sampled, then return to IDLE.
REQ-023 SHALL allow the next request to be accepted no earlier than the edge after the DONE->IDLE edge; there are no back-to-back overlapping operations.
REQ-024 SHALL ignore in_valid, op, a and b while busy; changes to them do not affect the operation in flight.
REQ-025 SHALL produce a deterministic result of 0 for MULH-class ops when either operand is 0.

Reset
REQ-026 SHALL, while reset_n=0, force the following regardless of clk:
- state IDLE;
- in_ready 1, out_valid 0, busy 0;
- result 0;
- iteration counter 0;
- accumulators 0.
REQ-027 SHALL, when reset is asserted mid-CALC or in DONE, abandon the operation with no result emitted; the first request after reset_n deasserts is processed normally.

Configuration
REQ-028 SHALL use the macro MULDIV_EARLY_OUT_EN.
REQ-029 SHALL, with MULDIV_EARLY_OUT_EN defined, route divide-by-zero and signed-overflow requests IDLE -> DONE directly, so out_valid asserts 1 cycle after accept.
REQ-030 SHALL, with MULDIV_EARLY_OUT_EN undefined, give every op WIDTH+1 cycle latency; result values are identical in both builds.

Verification (WIDTH=32)
REQ-031 SHALL cover MULHSU with a=0xFFFFFFFF (-1) and b=0x00000002 -> result 0xFFFFFFFF after 33 cycles; MUL with the same operands -> 0xFFFFFFFE.
REQ-032 SHALL cover DIV with a=-7 and b=2 -> 0xFFFFFFFD; REM with the same operands -> 0xFFFFFFFF; DIVU with a=7 and b=2 -> 3.
REQ-033 SHALL cover DIV with a=0x80000000 and b=0xFFFFFFFF -> 0x80000000, and REM -> 0; also DIVU with b=0 -> 0xFFFFFFFF, and REMU with b=0 -> a.
- Latency is 1 cycle with MULDIV_EARLY_OUT_EN defined and 33 cycles without it.
REQ-034 SHALL cover out_ready held 0 for 5 cycles after out_valid -> result stable, in_ready=0; an in_valid pulse in that window is not accepted.
REQ-035 SHALL cover reset_n pulsed low at CALC iteration 10 -> out_valid=0 and in_ready=1 immediately; a following MULHU with 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-036 SHALL cover randomly changing a, b and op during CALC -> the result matches the operands captured at accept.
